// File: rtl/csi2_raw10_pkt_ctrl.sv
// CSI-2 packet controller: forwards RAW10 payload words to the unpacker.
// Optional footer CRC-16 check when CSI2_CRC_CHECK_EN is defined.
module csi2_raw10_pkt_ctrl #(
  parameter logic [1:0]  CFG_VC   = 2'd0,
  parameter logic [5:0]  DT_RAW10 = 6'h2B,
  parameter logic [15:0] MAX_WC   = 16'd6400
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        in_valid_i,
  input  logic [31:0] in_word_i,
  input  logic        err_clr_i,
  output logic        pix_valid_o,
  output logic [31:0] pix_word_o,
  output logic        pix_last_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        frame_active_o,
  output logic [15:0] frame_num_o,
  output logic [15:0] line_count_o,
  output logic [3:0]  err_o
);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAYLOAD,
    S_FOOTER,
    S_SKIP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [13:0] cnt_q;
  logic [13:0] cnt_d;
  logic        first_q;
  logic        first_d;

  logic        fs_ev;
  logic        fe_ev;
  logic        pix_ev;
  logic        last_ev;
  logic [3:0]  err_set;
  logic        crc_bad;

  logic        pix_valid_q;
  logic [31:0] pix_word_q;
  logic        pix_last_q;
  logic        line_start_q;
  logic        frame_start_q;
  logic        frame_end_q;
  logic        frame_active_q;
  logic [15:0] frame_num_q;
  logic [15:0] line_count_q;
  logic [3:0]  err_q;

  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        is_short;
  logic        wc_bad;
  logic [13:0] pw;
  logic [13:0] pw1;

  assign vc       = in_word_i[7:6];
  assign dt       = in_word_i[5:0];
  assign wc       = in_word_i[23:8];
  assign is_short = (dt < 6'h10);
  assign pw       = 14'((17'(wc) + 17'd3) >> 2);
  assign pw1      = pw + 14'd1;

  assign wc_bad = (wc == 16'd0)
               || ((wc % 16'd5) != 16'd0)
               || (wc > MAX_WC)
               || !frame_active_q;

  // state, word counter and first-word flag
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // packet parsing: next state, counter and event strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    fs_ev   = 1'b0;
    fe_ev   = 1'b0;
    pix_ev  = 1'b0;
    last_ev = 1'b0;
    err_set = 4'b0000;
    if (in_valid_i) begin
      unique case (state_q)
        S_HDR: begin
          if (vc != CFG_VC) begin
            if (!is_short) begin
              state_d = S_SKIP;
              cnt_d   = pw1;
            end
          end else if (dt == 6'h00) begin
            fs_ev      = 1'b1;
            err_set[1] = frame_active_q;
          end else if (dt == 6'h01) begin
            fe_ev      = 1'b1;
            err_set[1] = !frame_active_q;
          end else if (dt == DT_RAW10) begin
            if (wc_bad) begin
              err_set[0] = 1'b1;
              err_set[1] = !frame_active_q;
              state_d    = S_SKIP;
              cnt_d      = (wc == 16'd0) ? 14'd1 : pw1;
            end else begin
              state_d = S_PAYLOAD;
              cnt_d   = pw;
              first_d = 1'b1;
            end
          end else if (!is_short) begin
            err_set[3] = 1'b1;
            state_d    = S_SKIP;
            cnt_d      = pw1;
          end
        end
        S_PAYLOAD: begin
          pix_ev  = 1'b1;
          first_d = 1'b0;
          if (cnt_q == 14'd1) begin
            last_ev = 1'b1;
            state_d = S_FOOTER;
          end else begin
            cnt_d = cnt_q - 14'd1;
          end
        end
        S_FOOTER: begin
          err_set[2] = crc_bad;
          state_d    = S_HDR;
        end
        S_SKIP: begin
          if (cnt_q == 14'd1) begin
            state_d = S_HDR;
          end else begin
            cnt_d = cnt_q - 14'd1;
          end
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  // registered outputs, frame/line tracking and sticky errors
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      pix_valid_q    <= 1'b0;
      pix_word_q     <= '0;
      pix_last_q     <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_active_q <= 1'b0;
      frame_num_q    <= '0;
      line_count_q   <= '0;
      err_q          <= '0;
    end else begin
      pix_valid_q   <= pix_ev;
      pix_last_q    <= last_ev;
      line_start_q  <= pix_ev & first_q;
      frame_start_q <= fs_ev;
      frame_end_q   <= fe_ev;
      if (pix_ev) begin
        pix_word_q <= in_word_i;
      end
      if (fs_ev) begin
        frame_active_q <= 1'b1;
        frame_num_q    <= wc;
        line_count_q   <= '0;
      end
      if (fe_ev) begin
        frame_active_q <= 1'b0;
      end
      if (last_ev && (line_count_q != 16'hFFFF)) begin
        line_count_q <= line_count_q + 16'd1;
      end
      err_q <= (err_clr_i ? 4'b0000 : err_q) | err_set;
    end
  end

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] rem_q;

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) begin
        r = (r >> 1) ^ 16'h8408;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  // fold in only the bytes still inside the word count
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (16'(i) < rem_q) begin
        crc_d = crc_byte(crc_d, in_word_i[8*i +: 8]);
      end
    end
  end

  // running CRC and remaining payload byte count
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      crc_q <= 16'hFFFF;
      rem_q <= '0;
    end else if (state_q == S_HDR && state_d == S_PAYLOAD) begin
      crc_q <= 16'hFFFF;
      rem_q <= wc;
    end else if (pix_ev) begin
      crc_q <= crc_d;
      rem_q <= (rem_q > 16'd4) ? rem_q - 16'd4 : 16'd0;
    end
  end

  assign crc_bad = (crc_q != in_word_i[15:0]);
`else
  assign crc_bad = 1'b0;
`endif

  assign pix_valid_o    = pix_valid_q;
  assign pix_word_o     = pix_word_q;
  assign pix_last_o     = pix_last_q;
  assign line_start_o   = line_start_q;
  assign frame_start_o  = frame_start_q;
  assign frame_end_o    = frame_end_q;
  assign frame_active_o = frame_active_q;
  assign frame_num_o    = frame_num_q;
  assign line_count_o   = line_count_q;
  assign err_o          = err_q;

endmodule

// File: doc/csi2_raw10_pkt_ctrl.md
Name: csi2_raw10_pkt_ctrl

Overview:
Packet-level controller in front of the RAW10 unpacker in the ISP input path. It parses 32-bit CSI-2 words from the lane merger, tracks frame and line state, and forwards only RAW10 long-packet payload words, with valid and last, to the unpacker. Other packets are dropped and protocol errors are flagged.

Parameters:
CFG_VC, 2'd0, virtual channel accepted; all other VCs are skipped.
DT_RAW10, 6'h2B, data type forwarded as pixel payload.
MAX_WC, 16'd6400, largest legal RAW10 word count in bytes; larger is an error.

Ports:
wb_clk_i  input  1  clock
wb_rst_n  input  1  reset, synchronous, active-low
in_valid_i  input  1  in_word_i valid this cycle; no backpressure
in_word_i  input  32  CSI-2 word, byte0 in [7:0]
err_clr_i  input  1  clears err_o sticky bits
pix_valid_o  output  1  pix_word_o valid, feeds unpacker data_valid
pix_word_o  output  32  RAW10 payload word
pix_last_o  output  1  last payload word of line
frame_start_o  output  1  one-cycle pulse on FS
frame_end_o  output  1  one-cycle pulse on FE
line_start_o  output  1  one-cycle pulse on first payload word of line
frame_active_o  output  1  high between FS and FE
frame_num_o  output  16  WC field of last FS
line_count_o  output  16  RAW10 lines received in current frame
err_o  output  4  sticky: [0] wc_err, [1] seq_err, [2] crc_err, [3] dt_skip

Behaviour:
- Reset (wb_rst_n=0 at posedge): state=HDR; all outputs 0; counters 0. Reset mid-packet abandons the packet without flags.
- Header word: DI=[7:0] (VC=[7:6], DT=[5:0]), WC=[23:8], ECC=[31:24]. ECC is ignored.
- Footer: always one separate word after the payload, CRC in [15:0], [31:16] ignored.
- Payload words: PW=(WC+3)>>2, 14-bit down-counter.
- States. All transitions require in_valid_i=1; idle cycles hold state.
- HDR, VC≠CFG_VC, DT<0x10: ignore the word, stay in HDR.
- HDR, VC≠CFG_VC, DT≥0x10: go to SKIP with count=PW+1.
- HDR, short packet DT=0x00 (FS): frame_start_o=1, frame_active_o=1, frame_num_o=WC, line_count_o=0. If already active, set seq_err.
- HDR, short packet DT=0x01 (FE): frame_end_o=1, frame_active_o=0. If not active, set seq_err.
- HDR, other short packets (DT<0x10): ignored.
- HDR, DT=DT_RAW10, WC valid: go to PAYLOAD, count=PW.
- WC is invalid if WC=0, WC%5≠0, WC>MAX_WC, or frame_active_o=0. An invalid WC sets wc_err (plus seq_err if the frame is inactive) and goes to SKIP with count=PW+1. If WC=0, go to SKIP with count=1.
- HDR, other long DT: set dt_skip, go to SKIP with count=PW+1.
- PAYLOAD:
  - Each word gives pix_valid_o=1 with pix_word_o=in_word_i, registered, 1-cycle latency.
  - line_start_o accompanies the first word.
  - On count=1: pix_last_o=1, line_count_o+=1 (saturates at 0xFFFF), go to FOOTER.
  - Other cycles: pix_valid_o=0 and pix_word_o holds its value.
- FOOTER: consume one word, go to HDR. Compare CRC only with the macro.
- SKIP: decrement count per word; at count=1 go to HDR.
- err_o bits stay set until err_clr_i=1. If a set event and err_clr_i occur in the same cycle, the set wins.
- Pulses are registered, so they appear 1 cycle after the accepting edge, aligned with pix outputs.

Optional Feature:
CSI2_CRC_CHECK_EN:
- Defined: a CRC-16 runs over the payload bytes only; bytes beyond WC in the last word are excluded.
  - Polynomial 0x1021, reflected/LSB-first, init 0xFFFF.
  - Up to 4 bytes are processed per cycle.
  - Mismatch against footer [15:0] sets crc_err; the pixels are still forwarded.
- Undefined: no CRC logic; err_o[2] is tied to 0.

Test Plan:
- Reset → FS(WC=7) → FE: frame_start_o pulse with frame_num_o=7, frame_active_o 1 then 0, frame_end_o pulse, err_o=0.
- FS, RAW10 WC=20 header, 5 payload words 0x11111111..0x55555555, footer → 5 pix_valid_o cycles in order, line_start_o on word1, pix_last_o on word5, line_count_o=1.
- In-frame RAW10 WC=18 → wc_err; SKIP consumes 5+1 words; pix_valid_o stays 0; next header is parsed normally.
- Header VC=1 DT=0x2B WC=20 → 6 words skipped, no outputs, no errors. Then FE with no FS → seq_err.
- in_valid_i gaps of 3 cycles inside the payload → word order and pix_last_o correct. Reset asserted during the 3rd payload word → all outputs 0 next cycle, the next FS is accepted.
- With CSI2_CRC_CHECK_EN: WC=20 payload all 0x00 bytes with correct footer CRC → err_o[2]=0. Flip one footer bit → err_o[2]=1, cleared by err_clr_i.
